dual_port_ram: RTL and testbench

- True dual-port synchronous RAM: 64 words of 8 bits by default.
- Two independent read/write ports (1 and 2) share one clock.
- Serves as a general-purpose on-chip buffer between two agents, for example a producer and a consumer, or two pipeline stages.
- Each port has registered read data.

---
 rtl/ram_pkg.sv | 23 ++
 rtl/dual_port_ram.sv | 72 +++++++
 tb/tb_dual_port_ram.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared defaults and word type for the dual-port RAM block.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Default geometry: 64 words of 8 bits.
    localparam int c_DATA_WIDTH = 8;
    localparam int c_ADDR_WIDTH = 6;
    localparam int c_DEPTH      = 2 ** c_ADDR_WIDTH;

    // One storage word at the default width.
    typedef logic [c_DATA_WIDTH-1:0] word_t;

    // Number of words addressable with a given address width.
    function automatic int depth_of(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage : ram_pkg
`default_nettype wire

// File: rtl/dual_port_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_ram
//  Description : True dual-port synchronous RAM, one shared clock, registered
//                read data on both ports. Write-first on the writing port,
//                read-before-write across ports, port 1 wins write collisions.
//  Revision    : 1.0 - initial release
// ============================================================================
module dual_port_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] data_2,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [ADDR_WIDTH-1:0] addr_2,
    input  logic                  we_1,
    input  logic                  we_2,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] q_1,
    output logic [DATA_WIDTH-1:0] q_2,
    input  logic                  rst_n
);

    // Depth follows the address width; every address value is a valid word.
    localparam int c_DEPTH_LOCAL = depth_of(ADDR_WIDTH);

    // Storage array: intentionally never reset so it maps onto block RAM and
    // keeps its contents across rst_n assertion.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH_LOCAL];

    // Registered read data for each port.
    logic [DATA_WIDTH-1:0] r_q_1;
    logic [DATA_WIDTH-1:0] r_q_2;

    // Qualified write strobes: writes are dropped while reset is held.
    logic w_wr_1;
    logic w_wr_2;

    assign w_wr_1 = we_1 & rst_n;
    assign w_wr_2 = we_2 & rst_n;

    // Array update; port 2 is written first so port 1 overrides it when both
    // ports target the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (w_wr_2) begin
            r_mem[addr_2] <= data_2;
        end
        if (w_wr_1) begin
            r_mem[addr_1] <= data_1;
        end
    end

    // Read registers: a writing port returns its own write data, otherwise
    // the pre-edge array contents (so a cross-port write is seen next cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_1 <= '0;
            r_q_2 <= '0;
        end else begin
            r_q_1 <= we_1 ? data_1 : r_mem[addr_1];
            r_q_2 <= we_2 ? data_2 : r_mem[addr_2];
        end
    end

    assign q_1 = r_q_1;
    assign q_2 = r_q_2;

endmodule : dual_port_ram
`default_nettype wire

// File: tb/tb_dual_port_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_port_ram
//  Description : Directed self-checking bench for dual_port_ram.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram;

    logic [7:0] data_1;
    logic [7:0] data_2;
    logic [5:0] addr_1;
    logic [5:0] addr_2;
    logic       we_1;
    logic       we_2;
    logic       clk;
    logic [7:0] q_1;
    logic [7:0] q_2;
    logic       rst_n;

    int n_cmp;
    int n_err;

    dual_port_ram #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (6)
    ) u_dut (
        .data_1 (data_1),
        .data_2 (data_2),
        .addr_1 (addr_1),
        .addr_2 (addr_2),
        .we_1   (we_1),
        .we_2   (we_2),
        .clk    (clk),
        .q_1    (q_1),
        .q_2    (q_2),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed byte against its hand-computed value.
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Drive both ports, then advance one rising edge and settle 1 time unit.
    task automatic cyc(input logic w1, input logic [5:0] a1, input logic [7:0] d1,
                       input logic w2, input logic [5:0] a2, input logic [7:0] d2);
        we_1 = w1; addr_1 = a1; data_1 = d1;
        we_2 = w2; addr_2 = a2; data_2 = d2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        we_1   = 1'b0; we_2   = 1'b0;
        addr_1 = '0;   addr_2 = '0;
        data_1 = '0;   data_2 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_q1", q_1, 8'h00);
        check("reset_q2", q_2, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Dual write
        cyc(1'b1, 6'd1, 8'h42, 1'b1, 6'd2, 8'h55);
        check("dualwr_q1", q_1, 8'h42);
        check("dualwr_q2", q_2, 8'h55);

        // Write on port 1, read on port 2
        cyc(1'b1, 6'd3, 8'h57, 1'b0, 6'd1, 8'h00);
        check("wr_rd_q1", q_1, 8'h57);
        check("wr_rd_q2", q_2, 8'h42);

        // Both read
        cyc(1'b0, 6'd2, 8'h00, 1'b0, 6'd3, 8'h00);
        check("rdrd_q1", q_1, 8'h55);
        check("rdrd_q2", q_2, 8'h57);

        // Overwrite from port 2
        cyc(1'b0, 6'd1, 8'h00, 1'b1, 6'd2, 8'h25);
        check("ovr_q1", q_1, 8'h42);
        check("ovr_q2", q_2, 8'h25);
        cyc(1'b0, 6'd2, 8'h00, 1'b0, 6'd0, 8'h00);
        check("ovr_rd_q1", q_1, 8'h25);

        // Cross-port same address: old value seen, new value next cycle
        cyc(1'b1, 6'd7, 8'h11, 1'b0, 6'd0, 8'h00);
        cyc(1'b1, 6'd7, 8'hAA, 1'b0, 6'd7, 8'h00);
        check("xport_q1", q_1, 8'hAA);
        check("xport_old_q2", q_2, 8'h11);
        cyc(1'b0, 6'd0, 8'h00, 1'b0, 6'd7, 8'h00);
        check("xport_new_q2", q_2, 8'hAA);

        // Collision: port 1 wins storage, each q shows its own data
        cyc(1'b1, 6'd5, 8'h10, 1'b1, 6'd5, 8'h20);
        check("coll_q1", q_1, 8'h10);
        check("coll_q2", q_2, 8'h20);
        cyc(1'b0, 6'd5, 8'h00, 1'b0, 6'd5, 8'h00);
        check("coll_rd_q1", q_1, 8'h10);
        check("coll_rd_q2", q_2, 8'h10);

        // Address boundaries 0 and 63, written and read through opposite ports
        cyc(1'b1, 6'd0, 8'hC3, 1'b1, 6'd63, 8'h3C);
        cyc(1'b0, 6'd63, 8'h00, 1'b0, 6'd0, 8'h00);
        check("bound_q1_a63", q_1, 8'h3C);
        check("bound_q2_a0", q_2, 8'hC3);

        // Hold: q keeps its value across an edge-free interval
        #3;
        check("hold_q1", q_1, 8'h3C);

        // Reset mid-cycle: q clears immediately, writes are ignored
        cyc(1'b0, 6'd1, 8'h00, 1'b0, 6'd3, 8'h00);
        check("pre_rst_q1", q_1, 8'h42);
        check("pre_rst_q2", q_2, 8'h57);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q1", q_1, 8'h00);
        check("async_rst_q2", q_2, 8'h00);
        cyc(1'b1, 6'd1, 8'hFF, 1'b1, 6'd3, 8'hEE);
        check("rst_hold_q1", q_1, 8'h00);
        check("rst_hold_q2", q_2, 8'h00);
        we_1 = 1'b0; we_2 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Contents preserved through reset, writes during reset discarded
        cyc(1'b0, 6'd1, 8'h00, 1'b0, 6'd3, 8'h00);
        check("post_rst_q1", q_1, 8'h42);
        check("post_rst_q2", q_2, 8'h57);
        cyc(1'b0, 6'd7, 8'h00, 1'b0, 6'd5, 8'h00);
        check("post_rst_a7", q_1, 8'hAA);
        check("post_rst_a5", q_2, 8'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dual_port_ram
`default_nettype wire
